// File: rtl/cpu_ad48_dmem_arb.sv
// Arbiter sharing the single synchronous DMEM port between the CPU and the debug/loader port.
// CPU has fixed priority, bounded by a debug starvation guard and a debug lock for atomic sequences.
module cpu_ad48_dmem_arb #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 48,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              cpu_req_valid,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_req_ready,
    output logic              cpu_rsp_valid,
    output logic [DATA_W-1:0] cpu_rsp_rdata,

    input  logic              dbg_req_valid,
    input  logic              dbg_req_we,
    input  logic [ADDR_W-1:0] dbg_req_addr,
    input  logic [DATA_W-1:0] dbg_req_wdata,
    input  logic              dbg_req_lock,
    output logic              dbg_req_ready,
    output logic              dbg_rsp_valid,
    output logic [DATA_W-1:0] dbg_rsp_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        OWN_FREE       = 1'b0,
        OWN_DBG_LOCKED = 1'b1
    } own_e;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    own_e       own_q, own_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       rsp_pend_q, rsp_pend_d;
    logic       rsp_who_q, rsp_who_d;

    logic       grant_cpu;
    logic       grant_dbg;

    // Grant decision; at most one requester wins per cycle.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no path leaves it unassigned (no latch).
        grant_cpu = 1'b0;
        grant_dbg = 1'b0;
        if (own_q == OWN_DBG_LOCKED) begin
            grant_dbg = dbg_req_valid;
        end else if (dbg_req_valid && (wait_cnt_q >= MAX_WAIT_C)) begin
            grant_dbg = 1'b1;
        end else if (cpu_req_valid) begin
            grant_cpu = 1'b1;
        end else begin
            grant_dbg = dbg_req_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            own_q      <= OWN_FREE;
            wait_cnt_q <= 4'd0;
            rsp_pend_q <= 1'b0;
            rsp_who_q  <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
            own_q      <= own_d;
            wait_cnt_q <= wait_cnt_d;
            rsp_pend_q <= rsp_pend_d;
            rsp_who_q  <= rsp_who_d;
        end
    end

    always_comb begin
        own_d      = own_q;
        wait_cnt_d = 4'd0;
        rsp_pend_d = 1'b0;
        rsp_who_d  = rsp_who_q;

        if (grant_dbg) begin
            own_d = dbg_req_lock ? OWN_DBG_LOCKED : OWN_FREE;
        end

        if (dbg_req_valid && !grant_dbg) begin
            wait_cnt_d = (wait_cnt_q == 4'd15) ? wait_cnt_q : wait_cnt_q + 4'd1;
        end

        if ((grant_cpu && !cpu_req_we) || (grant_dbg && !dbg_req_we)) begin
            rsp_pend_d = 1'b1;
            rsp_who_d  = grant_dbg;
        end
    end

    // Request-side outputs are forced idle while reset is held, even though grants are combinational.
    always_comb begin
        cpu_req_ready = 1'b0;
        dbg_req_ready = 1'b0;
        mem_en        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        if (resetn) begin
            if (grant_cpu) begin
                cpu_req_ready = 1'b1;
                mem_en        = 1'b1;
                mem_we        = cpu_req_we;
                mem_addr      = cpu_req_addr;
                mem_wdata     = cpu_req_wdata;
            end else if (grant_dbg) begin
                dbg_req_ready = 1'b1;
                mem_en        = 1'b1;
                mem_we        = dbg_req_we;
                mem_addr      = dbg_req_addr;
                mem_wdata     = dbg_req_wdata;
            end
        end

        cpu_rsp_valid = rsp_pend_q && !rsp_who_q;
        dbg_rsp_valid = rsp_pend_q && rsp_who_q;
        cpu_rsp_rdata = mem_rdata;
        dbg_rsp_rdata = mem_rdata;
    end

endmodule

// File: tb/tb_cpu_ad48_dmem_arb.sv
// Self-checking bench for cpu_ad48_dmem_arb: directed scenarios followed by randomized traffic,
// all compared against a transaction-level reference model with its own shadow memory.
module tb_cpu_ad48_dmem_arb;

    localparam int AW       = 7;
    localparam int DW       = 48;
    localparam int MAX_WAIT = 4;
    localparam int WORDS    = 1 << AW;

    logic          clk;
    logic          resetn;
    logic          cv, cwe, dv, dwe, dl;
    logic [AW-1:0] ca, da;
    logic [DW-1:0] cd, dd;
    logic          cpu_req_ready, cpu_rsp_valid, dbg_req_ready, dbg_rsp_valid;
    logic [DW-1:0] cpu_rsp_rdata, dbg_rsp_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    cpu_ad48_dmem_arb #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_req_valid(cv), .cpu_req_we(cwe), .cpu_req_addr(ca), .cpu_req_wdata(cd),
        .cpu_req_ready(cpu_req_ready), .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata),
        .dbg_req_valid(dv), .dbg_req_we(dwe), .dbg_req_addr(da), .dbg_req_wdata(dd),
        .dbg_req_lock(dl),
        .dbg_req_ready(dbg_req_ready), .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_rdata(dbg_rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment DMEM: synchronous, one-cycle read latency, contents survive reset.
    logic [DW-1:0] dmem [WORDS];
    logic [DW-1:0] rdata_q;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) dmem[mem_addr] <= mem_wdata;
            else        rdata_q <= dmem[mem_addr];
        end
    end
    assign mem_rdata = rdata_q;

    // Reference model: shadow memory, lock flag, debug stall count, expected response.
    logic [DW-1:0] ref_mem [WORDS];
    bit            m_locked;
    int            m_stall;
    bit            m_pend, m_who;
    logic [DW-1:0] m_data;
    bit            last_gc, last_gd;
    bit            obs_dbg_ready;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cpu(input logic v, input logic we, input int a, input logic [DW-1:0] d);
        cv = v; cwe = we; ca = AW'(a); cd = d;
    endtask

    task automatic set_dbg(input logic v, input logic we, input int a, input logic [DW-1:0] d, input logic l);
        dv = v; dwe = we; da = AW'(a); dd = d; dl = l;
    endtask

    task automatic model_reset();
        m_locked = 0; m_stall = 0; m_pend = 0; m_who = 0;
    endtask

    // One clock cycle: entered just after a falling edge with inputs already driven.
    task automatic step();
        bit gc, gd;
        #2;
        gc = 0; gd = 0;
        if (m_locked)                          gd = dv;
        else if (dv && (m_stall >= MAX_WAIT))  gd = 1;
        else if (cv)                           gc = 1;
        else                                   gd = dv;

        obs_dbg_ready = dbg_req_ready;
        check("cpu_req_ready", cpu_req_ready, gc);
        check("dbg_req_ready", dbg_req_ready, gd);
        check("mem_en", mem_en, gc | gd);
        check("mem_we", mem_we, gc ? cwe : (gd ? dwe : 1'b0));
        if (gc || gd) begin
            check("mem_addr", mem_addr, gc ? ca : da);
            if (gc ? cwe : dwe) check("mem_wdata", mem_wdata, gc ? cd : dd);
        end
        check("cpu_rsp_valid", cpu_rsp_valid, m_pend && !m_who);
        check("dbg_rsp_valid", dbg_rsp_valid, m_pend && m_who);
        if (m_pend) check(m_who ? "dbg_rsp_rdata" : "cpu_rsp_rdata",
                          m_who ? dbg_rsp_rdata : cpu_rsp_rdata, m_data);
        check("wait_cnt", dut.wait_cnt_q, m_stall);

        @(posedge clk);
        m_pend = (gc && !cwe) || (gd && !dwe);
        m_who  = gd;
        m_data = ref_mem[gd ? da : ca];
        if (gc && cwe) ref_mem[ca] = cd;
        if (gd && dwe) ref_mem[da] = dd;
        if (gd) m_locked = dl;
        m_stall = (dv && !gd) ? ((m_stall < 15) ? m_stall + 1 : 15) : 0;
        last_gc = gc;
        last_gd = gd;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int caddr;
        int dbg_cycle;

        for (int i = 0; i < WORDS; i++) begin
            dmem[i]    = DW'((i + 1) * 100);
            ref_mem[i] = DW'((i + 1) * 100);
        end
        resetn = 1'b0;
        set_cpu(0, 0, 0, '0);
        set_dbg(0, 0, 0, '0, 0);
        model_reset();

        // Reset holds every handshake output low even with both requesters active.
        @(negedge clk);
        set_cpu(1, 1, 3, 48'd1);
        set_dbg(1, 1, 5, 48'd2, 1);
        #2;
        check("rst_cpu_ready", cpu_req_ready, 1'b0);
        check("rst_dbg_ready", dbg_req_ready, 1'b0);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_cpu_rsp", cpu_rsp_valid, 1'b0);
        check("rst_dbg_rsp", dbg_rsp_valid, 1'b0);
        @(negedge clk);
        set_cpu(0, 0, 0, '0);
        set_dbg(0, 0, 0, '0, 0);
        resetn = 1'b1;

        // CPU-only write then read-back.
        set_cpu(1, 1, 4, 48'd12345); step();
        set_cpu(1, 0, 4, '0);        step();
        set_cpu(0, 0, 0, '0);        step();

        // Starvation guard: debug waits MAX_WAIT cycles, then wins once.
        caddr = 0;
        dbg_cycle = -1;
        set_dbg(1, 0, 8, '0, 0);
        for (int k = 0; k < 10; k++) begin
            set_cpu(caddr < 8, 0, caddr, '0);
            step();
            if (obs_dbg_ready && dbg_cycle < 0) dbg_cycle = k;
            if (last_gc) caddr++;
            if (last_gd) set_dbg(0, 0, 0, '0, 0);
        end
        check("starve_dbg_grant_cycle", 64'(dbg_cycle), 64'(MAX_WAIT));
        check("starve_cpu_done", 64'(caddr), 64'd8);

        // Lock: debug write with lock, idle with CPU pending, unlocking read.
        set_cpu(0, 0, 0, '0);
        set_dbg(1, 1, 2, 48'd67890, 1); step();
        set_cpu(1, 0, 5, '0);
        set_dbg(0, 0, 0, '0, 0);
        for (int k = 0; k < 3; k++) step();
        set_dbg(1, 0, 2, '0, 0);        step();
        set_dbg(0, 0, 0, '0, 0);        step();
        set_cpu(0, 0, 0, '0);           step();

        // Interleaved pipelined reads.
        for (int k = 0; k < 2; k++) begin
            set_cpu(1, 0, 1, '0); set_dbg(0, 0, 0, '0, 0); step();
            set_cpu(0, 0, 0, '0); set_dbg(1, 0, 3, '0, 0); step();
        end
        set_dbg(0, 0, 0, '0, 0); step();

        // Reset in the cycle after an accepted CPU read drops its response.
        set_cpu(1, 0, 6, '0); step();
        set_cpu(0, 0, 0, '0);
        resetn = 1'b0;
        #2;
        check("midrst_cpu_rsp", cpu_rsp_valid, 1'b0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        step();
        set_dbg(1, 0, 9, '0, 0); step();
        set_dbg(0, 0, 0, '0, 0); step();

        // Abort: debug drops valid while CPU holds the port.
        set_cpu(1, 0, 10, '0);
        set_dbg(1, 1, 11, 48'hdead, 0);
        step(); step();
        set_dbg(0, 0, 0, '0, 0);
        step(); step();
        set_cpu(1, 0, 11, '0); step();
        set_cpu(0, 0, 0, '0);  step();

        // Randomized traffic obeying hold-until-ready, with occasional debug aborts.
        for (int n = 0; n < 600; n++) begin
            if (!cv || last_gc)
                set_cpu($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                        {$urandom, $urandom});
            if (!dv || last_gd)
                set_dbg($urandom_range(0, 1) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                        {$urandom, $urandom}, $urandom_range(0, 3) == 0);
            else if ($urandom_range(0, 7) == 0)
                dv = 1'b0;
            step();
        end
        set_cpu(0, 0, 0, '0);
        set_dbg(0, 0, 0, '0, 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
